prog1_top_level: RTL and testbench
==================================

# prog1_top_level

Hardwired program-1 engine. On a request pulse it reads 15 packed 11-bit messages from on-chip data memory bytes 0–29, inserts Hamming SECDED parity (p8, p4, p2, p1 plus overall p0), and writes the 15 resulting 16-bit codewords to bytes 30–59. It signals completion with `done` and sits at the top of the design. The data memory is the only storage.

## Interface
- `NUM_MSGS`, default 15: number of messages processed.
- `DST_BASE`, default 30: byte address of the first output codeword (low byte).
- `MEM_DEPTH`, default 256: data memory depth in bytes.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req`  in  1: start request, sampled on the rising edge.
- `done`  out  1: program complete, held high until the next start.

## Operation
- Message i (0..14) source bytes:
  - hi = mem[2i+1]; bits [2:0] = d11..d9, bits [7:3] ignored.
  - lo = mem[2i]; bits [7:0] = d8..d1.
- Parity:
  - p8 = XOR(d11..d5)
  - p4 = XOR(d11..d8, d4..d2)
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = XOR(all d) ^ p8 ^ p4 ^ p2 ^ p1
- Output bytes:
  - mem[DST_BASE+2i+1] = {d11,d10,d9,d8,d7,d6,d5,p8}
  - mem[DST_BASE+2i] = {d4,d3,d2,p4,d1,p2,p1,p0}
- Source bytes 0–29 are never written. Bytes ≥60 are untouched.
- FSM states: IDLE, LD_HI, LD_LO, WR_HI, WR_LO, DONE.
  - IDLE/DONE with req=1 → LD_HI, i=0, done=0.
  - LD_HI: latch hi byte → LD_LO.
  - LD_LO: latch lo byte → WR_HI.
  - WR_HI: write high codeword byte → WR_LO.
  - WR_LO: write low byte; if i==NUM_MSGS-1 → DONE, else i++ → LD_HI.
  - DONE: done=1; remains until req=1.
- req while busy is ignored.
- Reset asserted: state=IDLE, i=0, done=0 immediately. Memory contents are NOT cleared, so a preload survives reset, and reset mid-run leaves already-written codewords in place.

## Timing
- Reset value of `done`: 0.
- Memory: combinational read, synchronous write, one write port.
- 4 cycles per message. `done` rises on the 60th rising edge after the edge that sampled req=1.
- Last codeword bytes are valid in memory when `done` is observed high.
- req=1 sampled in DONE: `done` drops on that same edge and the run restarts.

## Configuration
- `PROG1_TRACE_EN`:
  - Defined: after each WR_LO, a simulation-only `$display` prints message index, 11-bit data and 16-bit codeword in binary.
  - Undefined: no trace code. Synthesized behaviour is identical either way.

## Structure
- Package `prog1_pkg`:
  - state enum
  - constants NUM_MSGS, SRC_BASE=0, DST_BASE, MEM_DEPTH
  - pure function `hamming_encode(logic [11:1]) → logic [15:0]`
- Sub-module `data_mem`: instance name `dm1`, storage array `core[MEM_DEPTH]` of 8-bit bytes. Benches preload and inspect via `dm1.core`.

## Test plan
- All zeros: hi=0x00, lo=0x00 → mem[31]=0x00, mem[30]=0x00. done high 60 edges after req.
- All ones: hi=0x07, lo=0xFF → mem[31]=0xFF, mem[30]=0xFF.
- d1 only: hi=0x00, lo=0x01 → mem[31]=0x00, mem[30]=0x0F.
- d11 only, junk upper bits: hi=0xFC, lo=0x00 → mem[31]=0x81, mem[30]=0x17. Source bytes unchanged.
- 15 random messages vs. reference model → all 30 output bytes match. Re-pulse req from DONE → done drops, recomputes, same results.
- Reset low during message 7 WR_HI → done=0, FSM in IDLE, messages 0–6 outputs retained. A new req completes all 15.

Source files
------------

// File: rtl/prog1_pkg.sv
// prog1_pkg: FSM states, default sizing and the SECDED encoder shared by the program-1 engine.
package prog1_pkg;
    typedef enum logic [2:0] {IDLE, LD_HI, LD_LO, WR_HI, WR_LO, DONE} state_t;
    localparam int NUM_MSGS  = 15;
    localparam int SRC_BASE  = 0;
    localparam int DST_BASE  = 30;
    localparam int MEM_DEPTH = 256;
    function automatic logic [15:0] hamming_encode(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = ^{d[11:8], d[4:2]};
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction
endpackage

// File: rtl/prog1_top_level_data_mem.sv
// data_mem: byte-wide data memory, combinational read, synchronous single-port write, never cleared.
module data_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] core [MEM_DEPTH];
    always_ff @(posedge clk) begin
        if (we) core[wr_addr] <= wr_data;
    end
    assign rd_data = core[rd_addr];
endmodule

// File: rtl/prog1_top_level.sv
// prog1_top_level: encodes packed 11-bit messages into SECDED codewords in data memory.
// Define PROG1_TRACE_EN for a simulation-only per-message trace print.
module prog1_top_level #(
    parameter int NUM_MSGS  = prog1_pkg::NUM_MSGS,
    parameter int DST_BASE  = prog1_pkg::DST_BASE,
    parameter int MEM_DEPTH = prog1_pkg::MEM_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic done
);
    import prog1_pkg::*;
    localparam int AW = $clog2(MEM_DEPTH);

    state_t        state_q, state_d;
    logic [7:0]    i_q, i_d;
    logic [2:0]    hi_q, hi_d;
    logic [7:0]    lo_q, lo_d;
    logic [15:0]   code;
    logic          we;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [7:0]    wr_data, rd_data;

    data_mem #(.MEM_DEPTH(MEM_DEPTH)) dm1 (
        .clk(clk), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        code    = hamming_encode({hi_q, lo_q});
        rd_addr = AW'(SRC_BASE + 2 * int'(i_q) + ((state_q == LD_HI) ? 1 : 0));
        we      = (state_q == WR_HI) || (state_q == WR_LO);
        wr_addr = AW'(DST_BASE + 2 * int'(i_q) + ((state_q == WR_HI) ? 1 : 0));
        wr_data = (state_q == WR_HI) ? code[15:8] : code[7:0];
        case (state_q)
            IDLE, DONE: begin
                if (req) begin
                    state_d = LD_HI;
                    i_d     = '0;
                end
            end
            LD_HI: begin
                hi_d    = rd_data[2:0];
                state_d = LD_LO;
            end
            LD_LO: begin
                lo_d    = rd_data;
                state_d = WR_HI;
            end
            WR_HI: state_d = WR_LO;
            WR_LO: begin
                if (i_q == 8'(NUM_MSGS - 1)) state_d = DONE;
                else begin
                    i_d     = i_q + 8'd1;
                    state_d = LD_HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign done = (state_q == DONE);

`ifdef PROG1_TRACE_EN
    always @(posedge clk) begin
        if (state_q == WR_LO) $display("prog1 msg %0d data %b code %b", i_q, {hi_q, lo_q}, code);
    end
`else
`endif
endmodule

// File: tb/tb_prog1_top_level.sv
// tb_prog1_top_level: directed vector table plus multi-cycle sequences for the program-1 engine.
module tb_prog1_top_level;
    import prog1_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req = 1'b0;
    logic done;
    int checks = 0;
    int errors = 0;
    logic [7:0] src [30];

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] ehi;
        logic [7:0] elo;
    } vec_t;
    vec_t vt [4];

    prog1_top_level dut (.clk(clk), .reset(reset), .req(req), .done(done));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // classic position-indexed Hamming layout: parity k covers positions with bit k set
    function automatic logic [15:0] ref_enc(input logic [10:0] d);
        int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [15:0] c = '0;
        logic p;
        for (int j = 0; j < 11; j++) c[pos[j]] = d[j];
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int q = 1; q < 16; q++) if ((q & (1 << k)) != 0) p ^= c[q];
            c[1 << k] = p;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    task automatic run(input int pulse_at);
        int n;
        n = 0;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        chk("done_low_after_start", {31'd0, done}, 32'd0);
        while (!done && n < 200) begin
            req = (n + 1 == pulse_at);
            @(posedge clk);
            n++;
            #1 req = 1'b0;
        end
        chk("done_latency", n, 60);
    endtask

    task automatic check_msgs(input string name, input int first, input int last);
        logic [15:0] e;
        for (int i = first; i <= last; i++) begin
            e = ref_enc({src[2*i+1][2:0], src[2*i]});
            chk({name, "_hi"}, dut.dm1.core[31+2*i], e[15:8]);
            chk({name, "_lo"}, dut.dm1.core[30+2*i], e[7:0]);
        end
    endtask

    initial begin
        vt[0] = '{8'h00, 8'h00, 8'h00, 8'h00};
        vt[1] = '{8'h07, 8'hFF, 8'hFF, 8'hFF};
        vt[2] = '{8'h00, 8'h01, 8'h00, 8'h0F};
        vt[3] = '{8'hFC, 8'h00, 8'h81, 8'h17};

        #12 chk("reset_done", {31'd0, done}, 32'd0);
        for (int a = 0; a < 30; a++) dut.dm1.core[a] = 8'h00;
        for (int a = 30; a < 60; a++) dut.dm1.core[a] = 8'hAA;
        dut.dm1.core[60] = 8'h5A;
        for (int v = 0; v < 4; v++) begin
            dut.dm1.core[2*v+1] = vt[v].hi;
            dut.dm1.core[2*v]   = vt[v].lo;
        end
        @(negedge clk) reset = 1'b1;
        @(negedge clk);

        run(0);
        for (int v = 0; v < 4; v++) begin
            chk($sformatf("vec%0d_hi", v), dut.dm1.core[31+2*v], vt[v].ehi);
            chk($sformatf("vec%0d_lo", v), dut.dm1.core[30+2*v], vt[v].elo);
        end
        for (int i = 4; i < 15; i++) chk($sformatf("zero%0d", i), {dut.dm1.core[31+2*i], dut.dm1.core[30+2*i]}, 16'h0000);
        chk("src_unchanged_hi", dut.dm1.core[7], 8'hFC);
        chk("src_unchanged_lo", dut.dm1.core[6], 8'h00);
        chk("byte60_untouched", dut.dm1.core[60], 8'h5A);
        repeat (3) @(posedge clk);
        #1 chk("done_held", {31'd0, done}, 32'd1);

        for (int a = 0; a < 30; a++) begin
            src[a] = 8'($urandom);
            dut.dm1.core[a] = src[a];
        end
        run(0);
        check_msgs("rand", 0, 14);
        chk("rand_byte60", dut.dm1.core[60], 8'h5A);
        for (int a = 30; a < 60; a++) dut.dm1.core[a] = 8'h00;
        run(20);
        check_msgs("rerun", 0, 14);
        for (int a = 0; a < 30; a++) chk("rand_src_kept", dut.dm1.core[a], src[a]);

        for (int a = 30; a < 60; a++) dut.dm1.core[a] = 8'hAA;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("midrun_reset_done", {31'd0, done}, 32'd0);
        chk("midrun_reset_state", 32'(dut.state_q), 32'(IDLE));
        check_msgs("kept", 0, 6);
        for (int a = 44; a < 60; a++) chk("unwritten", dut.dm1.core[a], 8'hAA);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        run(0);
        check_msgs("after_reset", 0, 14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
